// File: rtl/fp_multiplier_top.sv
// Sequential IEEE-754 binary32 multiplier: operands arrive one after the other on a
// shared bus, a 24-cycle radix-2 shift-add produces the significand product, then one normalise cycle.
module fp_multiplier_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        resultaccept,
  input  logic [31:0] Tempbus,
  output logic [31:0] ResultBus,
  input  logic        ready,
  output logic        accept,
  output logic        doneMul,
  output logic        resultready
);

  localparam int unsigned WW = 32;  // word width
  localparam int unsigned EW = 8;   // exponent field width
  localparam int unsigned FW = 23;  // fraction field width
  localparam int unsigned SW = 24;  // significand width with hidden bit
  localparam int unsigned PW = 48;  // full significand product width
  localparam int unsigned CW = 5;   // multiply step counter width
  localparam int unsigned XW = 10;  // signed exponent arithmetic width

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    ACK_A  = 3'd1,
    GET_B  = 3'd2,
    ACK_B  = 3'd3,
    LOADED = 3'd4,
    MUL    = 3'd5,
    NORM   = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WW-1:0] r_a;
  logic [WW-1:0] r_b;
  logic [PW-1:0] r_mcand;
  logic [SW-1:0] r_mplier;
  logic [PW-1:0] r_prod;
  logic [CW-1:0] r_cnt;

  logic [EW-1:0]        w_ea;
  logic [EW-1:0]        w_eb;
  logic [FW-1:0]        w_fa;
  logic [FW-1:0]        w_fb;
  logic                 w_sign;
  logic                 w_a_zero;
  logic                 w_b_zero;
  logic                 w_a_inf;
  logic                 w_b_inf;
  logic                 w_a_nan;
  logic                 w_b_nan;
  logic                 w_shift;
  logic [PW-1:0]        w_norm_prod;
  logic [FW-1:0]        w_frac;
  logic signed [XW-1:0] w_exp;
  logic [WW-1:0]        w_result;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= GET_A;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      GET_A:   if (ready)         w_next = ACK_A;
      ACK_A:   if (!ready)        w_next = GET_B;
      GET_B:   if (ready)         w_next = ACK_B;
      ACK_B:   if (!ready)        w_next = LOADED;
      LOADED:  if (start)         w_next = MUL;
      MUL:     if (r_cnt == CW'(SW - 1)) w_next = NORM;
      NORM:                       w_next = DONE;
      DONE:    if (resultaccept)  w_next = GET_A;
      default:                    w_next = GET_A;
    endcase
  end

  // Operand classification and normalised result
  always_comb begin
    w_ea     = r_a[WW-2 -: EW];
    w_eb     = r_b[WW-2 -: EW];
    w_fa     = r_a[FW-1:0];
    w_fb     = r_b[FW-1:0];
    w_sign   = r_a[WW-1] ^ r_b[WW-1];
    w_a_zero = (w_ea == '0);
    w_b_zero = (w_eb == '0);
    w_a_inf  = (w_ea == '1) && (w_fa == '0);
    w_b_inf  = (w_eb == '1) && (w_fb == '0);
    w_a_nan  = (w_ea == '1) && (w_fa != '0);
    w_b_nan  = (w_eb == '1) && (w_fb != '0);

    w_shift     = r_prod[PW-1];
    w_norm_prod = w_shift ? (r_prod >> 1) : r_prod;
    w_frac      = FW'(w_norm_prod >> FW);
    w_exp       = $signed(XW'(w_ea) + XW'(w_eb) - XW'(127) + XW'(w_shift));

    w_result = {w_sign, EW'(w_exp), w_frac};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_result = 32'h7FC0_0000;
    else if (w_a_inf || w_b_inf)
      w_result = {w_sign, {EW{1'b1}}, {FW{1'b0}}};
    else if (w_a_zero || w_b_zero)
      w_result = {w_sign, {(WW-1){1'b0}}};
    else if (w_exp >= XW'(255))
      w_result = {w_sign, {EW{1'b1}}, {FW{1'b0}}};
    else if (w_exp <= $signed(XW'(0)))
      w_result = {w_sign, {(WW-1){1'b0}}};
  end

  // Operand capture, shift-add datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
      ResultBus   <= '0;
      accept      <= 1'b0;
      doneMul     <= 1'b0;
      resultready <= 1'b0;
    end else begin
      doneMul <= 1'b0;
      case (r_state)
        GET_A: if (ready) begin
          r_a    <= Tempbus;
          accept <= 1'b1;
        end
        ACK_A: if (!ready) accept <= 1'b0;
        GET_B: if (ready) begin
          r_b    <= Tempbus;
          accept <= 1'b1;
        end
        ACK_B: if (!ready) accept <= 1'b0;
        LOADED: if (start) begin
          r_mcand  <= PW'({1'b1, r_a[FW-1:0]});
          r_mplier <= {1'b1, r_b[FW-1:0]};
          r_prod   <= '0;
          r_cnt    <= '0;
        end
        MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        NORM: begin
          ResultBus   <= w_result;
          doneMul     <= 1'b1;
          resultready <= 1'b1;
        end
        DONE: if (resultaccept) resultready <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier_top.sv
// Bench for fp_multiplier_top: directed vector table, handshake/reset corner sequences,
// and random operands checked against a field-level arithmetic reference model.
module tb_fp_multiplier_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        resultaccept;
  logic [31:0] Tempbus;
  logic [31:0] ResultBus;
  logic        ready;
  logic        accept;
  logic        doneMul;
  logic        resultready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  fp_multiplier_top dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .resultaccept (resultaccept),
    .Tempbus      (Tempbus),
    .ResultBus    (ResultBus),
    .ready        (ready),
    .accept       (accept),
    .doneMul      (doneMul),
    .resultready  (resultready)
  );

  // Reference: exact integer significand product, truncated, with IEEE field rules
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int              ea, eb, e;
    logic [22:0]     fa, fb, f;
    logic            s, nan, ia, ib, za, zb;
    longint unsigned p;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    fa  = a[22:0];
    fb  = b[22:0];
    nan = (ea == 255 && fa != 0) || (eb == 255 && fb != 0);
    ia  = (ea == 255 && fa == 0);
    ib  = (eb == 255 && fb == 0);
    za  = (ea == 0);
    zb  = (eb == 0);
    if (nan || (ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    p = 64'({1'b1, fa}) * 64'({1'b1, fb});
    e = ea + eb - 127;
    if (p >= 64'h8000_0000_0000) begin
      e = e + 1;
      f = 23'(p / 64'h100_0000);
    end else begin
      f = 23'(p / 64'h80_0000);
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand, hold ready for 'hold' extra cycles while the bus changes, then drop it
  task automatic load_op(input logic [31:0] v, input int hold);
    Tempbus = v;
    ready   = 1'b1;
    @(posedge clk); #1;
    check("accept_rise", 32'(accept), 32'd1);
    for (int i = 0; i < hold; i++) begin
      Tempbus = $urandom;
      @(posedge clk); #1;
      check("accept_hold", 32'(accept), 32'd1);
    end
    ready   = 1'b0;
    Tempbus = $urandom;
    @(posedge clk); #1;
    check("accept_fall", 32'(accept), 32'd0);
  endtask

  // Launch from LOADED, measure latency, check product and result handshake
  task automatic do_mul(input logic [31:0] exp, input string name);
    int   n;
    logic seen;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      n = i;
      if (doneMul) seen = 1'b1;
    end
    check({name, "_latency"}, 32'(n), 32'd25);
    check({name, "_result"}, ResultBus, exp);
    check({name, "_rready"}, 32'(resultready), 32'd1);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, 32'(doneMul), 32'd0);
    check({name, "_rready_hold"}, 32'(resultready), 32'd1);
    resultaccept = 1'b1;
    @(posedge clk); #1;
    check({name, "_rready_clr"}, 32'(resultready), 32'd0);
    @(posedge clk); #1;
    resultaccept = 1'b0;
    check({name, "_rready_stay"}, 32'(resultready), 32'd0);
    check({name, "_result_keep"}, ResultBus, exp);
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input string name);
    load_op(a, 0);
    load_op(b, 0);
    do_mul(exp, name);
  endtask

  initial begin
    int pulses;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h41440000, 32'hC0600000, 32'hC22B8000};
    vecs[1] = '{32'h40100000, 32'h418C0000, 32'h421D8000};
    vecs[2] = '{32'h3F800000, 32'h00000000, 32'h00000000};
    vecs[3] = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
    vecs[4] = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[5] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vecs[6] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[7] = '{32'h00800000, 32'h00800000, 32'h00000000};
    vecs[8] = '{32'h80000000, 32'h3F800000, 32'h80000000};
    vecs[9] = '{32'hFF800000, 32'h3F800000, 32'hFF800000};

    rst = 1'b1;
    start = 1'b0;
    resultaccept = 1'b0;
    ready = 1'b0;
    Tempbus = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_accept", 32'(accept), 32'd0);
    check("rst_done", 32'(doneMul), 32'd0);
    check("rst_rready", 32'(resultready), 32'd0);
    check("rst_result", ResultBus, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_mul(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Long ready hold latches only the first bus value; start before B is ignored
    load_op(32'h40400000, 4);
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (doneMul) pulses++;
    end
    start = 1'b0;
    check("early_start_pulses", 32'(pulses), 32'd0);
    check("early_start_rready", 32'(resultready), 32'd0);
    load_op(32'h40000000, 0);
    do_mul(32'h40C00000, "held_ready");

    // Asynchronous reset mid-multiply, then a clean operation
    load_op(32'h41440000, 0);
    load_op(32'hC0600000, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_result", ResultBus, 32'd0);
    check("midrst_rready", 32'(resultready), 32'd0);
    check("midrst_accept", 32'(accept), 32'd0);
    check("midrst_done", 32'(doneMul), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (doneMul) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    run_mul(32'h40100000, 32'h418C0000, 32'h421D8000, "after_rst");

    // Random operands: half unconstrained, half with mid-range exponents
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) begin
        ra[30:23] = 8'(100 + $urandom_range(0, 54));
        rb[30:23] = 8'(100 + $urandom_range(0, 54));
      end
      run_mul(ra, rb, ref_mul(ra, rb), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
